// File: rtl/bus_pkg.sv
// Shared constants and FSM state type for the bus memory responder.
package bus_pkg;

   localparam int unsigned BEATS_PER_LINE    = 8;
   localparam int unsigned BEAT_W            = 3;
   localparam int unsigned LINE_OFFSET_BITS  = 6;
   localparam int unsigned TAG_WR_BIT        = 12;

   typedef enum logic [1:0] {
      StIdle,
      StWrData,
      StRdWait,
      StRdResp
   } state_t;

endpackage

// File: rtl/resp_mem_array.sv
// Backing store: one synchronous write port, one combinational read port, never cleared.
module resp_mem_array #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned WORDS      = 4096,
   parameter int unsigned ADDR_W     = $clog2(WORDS)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Line-oriented memory responder: 8-beat write bursts in, 8-beat read bursts out after a
// fixed latency. All bus outputs are registered.
module bus_mem_responder
   import bus_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned MEM_WORDS      = 4096,
   parameter int unsigned LATENCY        = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
   localparam int unsigned LINE_W = ADDR_W - BEAT_W;
   localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
   localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(LATENCY - 1);

   state_t                     state;
   logic [LINE_W-1:0]          line_q;
   logic [BEAT_W-1:0]          beat_q;
   logic [LAT_W-1:0]           lat_q;
   logic [BUS_TAG_WIDTH-1:0]   tag_q;

   logic                       beat_take;
   logic                       mem_we;
   logic [BEAT_W-1:0]          rd_beat;
   logic [ADDR_W-1:0]          mem_waddr;
   logic [ADDR_W-1:0]          mem_raddr;
   logic [BUS_DATA_WIDTH-1:0]  mem_rdata;

   // A beat is taken only when no ack is outstanding, so acks are never back to back.
   assign beat_take = bus_reqcyc && !bus_reqack;
   assign mem_we    = (state == StWrData) && beat_take;
   assign mem_waddr = {line_q, beat_q};

   // Look one beat ahead so the registered response can load the next word on respack.
   assign rd_beat   = (state == StRdResp) ? beat_q + 3'd1 : 3'd0;
   assign mem_raddr = {line_q, rd_beat};

   resp_mem_array #(
      .DATA_WIDTH (BUS_DATA_WIDTH),
      .WORDS      (MEM_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (bus_req),
      .rd_addr (mem_raddr),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         line_q      <= '0;
         beat_q      <= '0;
         lat_q       <= '0;
         tag_q       <= '0;
         bus_reqack  <= 1'b0;
         bus_respcyc <= 1'b0;
         bus_resp    <= '0;
         bus_resptag <= '0;
      end else begin
         bus_reqack <= 1'b0;
         unique case (state)
            StIdle: begin
               if (beat_take) begin
                  bus_reqack <= 1'b1;
                  line_q     <= bus_req[LINE_OFFSET_BITS +: LINE_W];
                  tag_q      <= bus_reqtag;
                  beat_q     <= '0;
                  lat_q      <= '0;
                  state      <= bus_reqtag[TAG_WR_BIT] ? StWrData : StRdWait;
               end
            end
            StWrData: begin
               if (beat_take) begin
                  bus_reqack <= 1'b1;
                  beat_q     <= beat_q + 3'd1;
                  if (beat_q == LAST_BEAT) begin
                     state <= StIdle;
                  end
               end
            end
            StRdWait: begin
               if (lat_q == LAST_LAT) begin
                  state       <= StRdResp;
                  bus_respcyc <= 1'b1;
                  bus_resp    <= mem_rdata;
                  bus_resptag <= tag_q;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            StRdResp: begin
               if (bus_respack) begin
                  if (beat_q == LAST_BEAT) begin
                     bus_respcyc <= 1'b0;
                     bus_resp    <= '0;
                     beat_q      <= '0;
                     state       <= StIdle;
                  end else begin
                     beat_q   <= beat_q + 3'd1;
                     bus_resp <= mem_rdata;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized bench for bus_mem_responder against a word-array model of the line memory.
module tb_bus_mem_responder;

   localparam int unsigned DW        = 64;
   localparam int unsigned TW        = 13;
   localparam int unsigned MEM_WORDS = 4096;
   localparam int unsigned LATENCY   = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          bus_reqcyc;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_reqack;
   logic          bus_respcyc;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;
   logic          bus_respack;

   bus_mem_responder #(
      .BUS_DATA_WIDTH (DW),
      .BUS_TAG_WIDTH  (TW),
      .MEM_WORDS      (MEM_WORDS),
      .LATENCY        (LATENCY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   logic [DW-1:0]        model_mem [MEM_WORDS];
   longint unsigned      lines [$];

   int unsigned ack_cnt  = 0;
   int unsigned dbl_ack  = 0;
   int unsigned resp_nz  = 0;
   logic        ack_prev = 1'b0;

   always @(posedge clk) begin
      if (bus_reqack) ack_cnt <= ack_cnt + 1;
      if (bus_reqack && ack_prev) dbl_ack <= dbl_ack + 1;
      ack_prev <= bus_reqack;
      if (!bus_respcyc && bus_resp != '0) resp_nz <= resp_nz + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned widx(input longint unsigned addr, input int unsigned k);
      return int'((((addr >> 6) * 8) + k) % MEM_WORDS);
   endfunction

   task automatic wait_ack(input string tag, output int cyc);
      bit ok = 1'b0;
      cyc = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (bus_reqack) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq(tag, 64'(ok), 64'd1);
   endtask

   task automatic do_write(input longint unsigned addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] data [8], input bit gaps);
      int          cyc;
      int unsigned acks0 = ack_cnt;
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      wait_ack("wr hdr ack", cyc);
      for (int k = 0; k < 8; k++) begin
         bus_req = data[k];
         if (gaps) begin
            bus_reqcyc = 1'b0;
            repeat ($urandom % 3) begin @(posedge clk); #1; end
            bus_reqcyc = 1'b1;
         end
         wait_ack("wr beat ack", cyc);
      end
      bus_reqcyc = 1'b0;
      @(posedge clk); #1;
      check_eq("wr ack pulses", 64'(ack_cnt - acks0), 64'd9);
      check_eq("wr ack idle", 64'(bus_reqack), 64'd0);
      for (int k = 0; k < 8; k++) model_mem[widx(addr, k)] = data[k];
      lines.push_back(addr);
   endtask

   task automatic do_read(input longint unsigned addr, input logic [TW-1:0] tag,
                          input int stall_beat, input int stall_len, input int abort_beat,
                          input bit hdr_done, input bit req_pend,
                          input longint unsigned nxt_addr, input logic [TW-1:0] nxt_tag);
      int            cyc;
      int            lat;
      int            stall;
      int unsigned   acks0;
      logic [DW-1:0] exp;
      if (!hdr_done) begin
         bus_reqcyc = 1'b1;
         bus_req    = addr;
         bus_reqtag = tag;
         wait_ack("rd hdr ack", cyc);
      end
      bus_reqcyc = 1'b0;
      lat = 0;
      for (int i = 0; i < int'(LATENCY) + 8; i++) begin
         bus_respack = 1'($urandom % 2);
         @(posedge clk); #1;
         lat++;
         if (bus_respcyc) break;
      end
      bus_respack = 1'b0;
      check_eq("rd latency", 64'(lat), 64'(LATENCY));
      acks0 = ack_cnt;
      for (int k = 0; k < 8; k++) begin
         exp = model_mem[widx(addr, k)];
         check_eq("rd data", bus_resp, exp);
         check_eq("rd tag", 64'(bus_resptag), 64'(tag));
         check_eq("rd respcyc", 64'(bus_respcyc), 64'd1);
         if (k == abort_beat) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_eq("abort respcyc", 64'(bus_respcyc), 64'd0);
            check_eq("abort resp", bus_resp, 64'd0);
            check_eq("abort resptag", 64'(bus_resptag), 64'd0);
            check_eq("abort reqack", 64'(bus_reqack), 64'd0);
            repeat (LATENCY + 3) begin @(posedge clk); #1; end
            check_eq("abort quiet", 64'(bus_respcyc), 64'd0);
            return;
         end
         if (req_pend && k == 2) begin
            bus_reqcyc = 1'b1;
            bus_req    = nxt_addr;
            bus_reqtag = nxt_tag;
         end
         stall = (k == stall_beat) ? stall_len : int'($urandom % 3);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check_eq("rd hold", bus_resp, exp);
         end
         bus_respack = 1'b1;
         @(posedge clk); #1;
         bus_respack = 1'b0;
      end
      check_eq("rd end respcyc", 64'(bus_respcyc), 64'd0);
      check_eq("rd end resp", bus_resp, 64'd0);
      if (req_pend) begin
         check_eq("no ack in burst", 64'(ack_cnt - acks0), 64'd0);
         wait_ack("pend ack", cyc);
         check_eq("pend ack cycle", 64'(cyc), 64'd1);
      end
   endtask

   logic [DW-1:0] wdata [8];

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset reqack", 64'(bus_reqack), 64'd0);
      check_eq("reset respcyc", 64'(bus_respcyc), 64'd0);
      check_eq("reset resp", bus_resp, 64'd0);
      check_eq("reset resptag", 64'(bus_resptag), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) wdata[k] = 64'h11 * 64'(k + 1);
      do_write(64'h1000, 13'h1005, wdata, 1'b0);
      do_read(64'h1020, 13'h0005, -1, 0, -1, 1'b0, 1'b0, 0, '0);
      do_read(64'h1000, 13'h0007, 3, 5, -1, 1'b0, 1'b0, 0, '0);

      for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
      do_write(64'h3FFF8, 13'h1ABC, wdata, 1'b1);
      do_read(64'h7FFC0, 13'h0ABC, -1, 0, -1, 1'b0, 1'b0, 0, '0);

      do_read(64'h1000, 13'h0011, -1, 0, -1, 1'b0, 1'b1, 64'h3FFC0, 13'h0022);
      do_read(64'h3FFC0, 13'h0022, -1, 0, -1, 1'b1, 1'b0, 0, '0);

      do_read(64'h1000, 13'h0033, -1, 0, 4, 1'b0, 1'b0, 0, '0);
      do_read(64'h1000, 13'h0034, -1, 0, -1, 1'b0, 1'b0, 0, '0);

      for (int it = 0; it < 24; it++) begin
         if ($urandom % 2 == 0) begin
            longint unsigned a;
            a = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
            do_write(a, 13'h1000 | 13'($urandom % 4096), wdata, 1'b1);
         end else begin
            longint unsigned a;
            a = lines[$urandom % lines.size()];
            a = (a & ~64'h3F) | 64'($urandom % 64);
            do_read(a, 13'($urandom % 4096), int'($urandom % 8), int'($urandom % 4), -1,
                    1'b0, 1'b0, 0, '0);
         end
      end

      @(posedge clk); #1;
      check_eq("back-to-back acks", 64'(dbl_ack), 64'd0);
      check_eq("resp nonzero while idle", 64'(resp_nz), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
